// File: rtl/mul_sched_rr_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
//
// Contents:
//   DEF_N_REQ / DEF_WIDTH / DEF_ID_W : default parameter values
//   state_t                          : scheduler FSM encoding (IDLE=0, RUN=1)
//   cnt_width()                      : iteration counter width for a given operand width
package mul_sched_rr_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_ID_W  = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // The counter must reach WIDTH-1; a width of at least one bit keeps
    // degenerate WIDTH=1 builds legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_sched_rr_serial_mul_core.sv
// Unsigned serial shift-add multiplier, one iteration per clock.
// Latency: WIDTH cycles from the start edge; o_done/o_product are valid during the last iteration.
// Backpressure: none; a start is only issued by the scheduler while the core is idle.
//
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   i_start     : load operands and begin (one-cycle pulse)
//   i_mcand     : multiplicand, latched on i_start
//   i_mplier    : multiplier, latched on i_start
//   o_done      : high during the final iteration cycle (combinational)
//   o_product   : accumulator value that the final iteration will produce
module serial_mul_core
    import mul_sched_rr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_run;

    logic [2*WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_last;

    // The low half of the accumulator starts as the multiplier and is
    // consumed one bit per iteration from the LSB; the multiplicand is added
    // into the high half. The sum is one bit wider so the carry out of the
    // addition survives the right shift.
    always_comb begin
        w_sum = {1'b0, r_acc};
        if (r_acc[0]) begin
            w_sum = {1'b0, r_acc} + {1'b0, r_mcand, {WIDTH{1'b0}}};
        end
        w_acc_nxt = (2*WIDTH)'(w_sum >> 1);
    end

    assign w_last    = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_done    = w_last;
    assign o_product = w_acc_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (i_start) begin
            r_mcand <= i_mcand;
            r_acc   <= {{WIDTH{1'b0}}, i_mplier};
            r_cnt   <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_sched_rr.sv
// Round-robin scheduler sharing one serial multiplier among N_REQ requesters.
// Latency: grant pulse 1 cycle after req seen in IDLE; Product_Valid 8 cycles after grant (WIDTH=8).
// Backpressure: requesters hold req+operands until granted; one op in flight, next req sampled on return to IDLE.
//
// Ports:
//   CLK, RST_N     : clock, asynchronous active-low reset
//   req            : per-requester request lines
//   a_bus, b_bus   : per-requester operands, slice i = [i*WIDTH +: WIDTH]
//   grant          : one-hot acceptance pulse
//   busy           : operation in progress
//   Product        : last result, held until the next one
//   Product_Valid  : one-cycle pulse marking a new Product/product_id
//   product_id     : requester index owning Product
module mul_sched_rr
    import mul_sched_rr_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_bus,
    input  logic [N_REQ*WIDTH-1:0]   b_bus,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [2*WIDTH-1:0]       Product,
    output logic                     Product_Valid,
    output logic [ID_W-1:0]          product_id
);

    state_t               r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_id;
    logic [N_REQ-1:0]     r_grant;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_valid;
    logic [ID_W-1:0]      r_product_id;

    logic [ID_W-1:0]      w_pick;
    logic [N_REQ-1:0]     w_grant_oh;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic                 w_start;
    logic                 w_core_done;
    logic [2*WIDTH-1:0]   w_core_product;

    // First set request searching upward from last+1 with wrap-around.
    // Walking the offsets from farthest to nearest lets the nearest hit
    // overwrite the others, so no early exit is needed.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        pick = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % N_REQ);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    assign w_pick     = rr_pick(req, r_ptr);
    assign w_grant_oh = N_REQ'(1) << w_pick;
    assign w_start    = (r_state == S_IDLE) && (|req);

    // Operand mux for the winning requester.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == ID_W'(i)) begin
                w_a = a_bus[i*WIDTH +: WIDTH];
                w_b = b_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    serial_mul_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_start   (w_start),
        .i_mcand   (w_a),
        .i_mplier  (w_b),
        .o_done    (w_core_done),
        .o_product (w_core_product)
    );

    // Scheduler FSM with registered outputs. The core latches operands on
    // the same edge that issues the grant, so later operand changes on the
    // bus cannot reach the datapath.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_ptr        <= ID_W'(N_REQ - 1);  // requester 0 searched first
            r_id         <= '0;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_product    <= '0;
            r_valid      <= 1'b0;
            r_product_id <= '0;
        end else begin
            r_grant <= '0;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant <= w_grant_oh;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_pick;
                        r_id    <= w_pick;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_core_done) begin
                        r_product    <= w_core_product;
                        r_product_id <= r_id;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign busy          = r_busy;
    assign Product       = r_product;
    assign Product_Valid = r_valid;
    assign product_id    = r_product_id;

endmodule
